tlc_request_latch: RTL and testbench

//  Upstream conditioner for the 4-way traffic light controller (tlc).

---
 rtl/tlc_pkg.sv | 21 ++
 rtl/tlc_debounce.sv | 43 ++++
 rtl/tlc_request_latch.sv | 79 +++++++
 tb/tb_tlc_request_latch.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller family: side count,
// side encoding and the default sensor debounce length.
package tlc_pkg;

   localparam int N_SIDES          = 4;
   localparam int DEBOUNCE_CYC_DEF = 4;

   // Side i maps to one-hot bit i on t, G, sensor_raw and starved.
   typedef enum logic [1:0] {
      SIDE1 = 2'b00,
      SIDE2 = 2'b01,
      SIDE3 = 2'b10,
      SIDE4 = 2'b11
   } side_e;

   function automatic logic [N_SIDES-1:0] side_onehot(input side_e side);
      side_onehot = '0;
      side_onehot[side] = 1'b1;
   endfunction

endpackage

// File: rtl/tlc_debounce.sv
// Two-flop synchroniser followed by a stability debouncer for one vehicle
// sensor; the level changes only after DEBOUNCE_CYC consecutive differing samples.
module tlc_debounce
   import tlc_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
   input  logic clkdiv,
   input  logic rst,
   input  logic sensor_raw,
   output logic deb
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             s1_p0;
   logic             s2_p1;
   logic [CNT_W-1:0] cnt_p2;

   always_ff @(posedge clkdiv) begin
      if (rst) begin
         s1_p0  <= 1'b0;
         s2_p1  <= 1'b0;
         cnt_p2 <= '0;
         deb    <= 1'b0;
      end else begin
         // synchroniser stages
         s1_p0 <= sensor_raw;
         s2_p1 <= s1_p0;
         // debounce stage: any agreement with the current level restarts the count
         if (s2_p1 == deb) begin
            cnt_p2 <= '0;
         end else if (cnt_p2 == CNT_LAST) begin
            deb    <= s2_p1;
            cnt_p2 <= '0;
         end else begin
            cnt_p2 <= cnt_p2 + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tlc_request_latch.sv
// Request conditioner ahead of tlc: debounced per-side sensors become latched
// requests on t, cleared when that side's green starts, with wait/starvation tracking.
module tlc_request_latch #(
   parameter int N_SIDES      = tlc_pkg::N_SIDES,
   parameter int DEBOUNCE_CYC = tlc_pkg::DEBOUNCE_CYC_DEF,
   parameter int WAIT_W       = 8,
   parameter int MAX_WAIT     = 200
) (
   input  logic               clkdiv,
   input  logic               rst,
   input  logic [N_SIDES-1:0] sensor_raw,
   input  logic [N_SIDES-1:0] G,
   output logic [N_SIDES-1:0] t,
   output logic [2:0]         pending_cnt,
   output logic [N_SIDES-1:0] starved
);

   localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

   logic [N_SIDES-1:0] deb;
   logic [N_SIDES-1:0] g_q;
   logic [N_SIDES-1:0] served;
   logic [N_SIDES-1:0] t_next;
   logic [N_SIDES-1:0] starved_next;
   logic [WAIT_W-1:0]  wait_q    [N_SIDES];
   logic [WAIT_W-1:0]  wait_next [N_SIDES];

   for (genvar i = 0; i < N_SIDES; i++) begin : g_side
      tlc_debounce #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_debounce (
         .clkdiv     (clkdiv),
         .rst        (rst),
         .sensor_raw (sensor_raw[i]),
         .deb        (deb[i])
      );
   end

   // Served = green rising edge; it dominates a same-cycle set.
   assign served = G & ~g_q;

   always_comb begin
      t_next       = t;
      starved_next = '0;
      for (int i = 0; i < N_SIDES; i++) begin
         wait_next[i] = '0;
         if (served[i]) begin
            t_next[i] = 1'b0;
         end else if (deb[i] && !G[i]) begin
            t_next[i] = 1'b1;
         end
         if (!served[i] && t[i]) begin
            wait_next[i] = (wait_q[i] == WAIT_SAT) ? WAIT_SAT : wait_q[i] + 1'b1;
         end
         starved_next[i] = (wait_next[i] >= WAIT_LIMIT);
      end
   end

   always_ff @(posedge clkdiv) begin
      if (rst) begin
         g_q     <= '0;
         t       <= '0;
         starved <= '0;
         for (int i = 0; i < N_SIDES; i++) wait_q[i] <= '0;
      end else begin
         g_q     <= G;
         t       <= t_next;
         starved <= starved_next;
         for (int i = 0; i < N_SIDES; i++) wait_q[i] <= wait_next[i];
      end
   end

   always_comb begin
      pending_cnt = '0;
      for (int i = 0; i < N_SIDES; i++) pending_cnt = pending_cnt + 3'(t[i]);
   end

endmodule

// File: tb/tb_tlc_request_latch.sv
// Directed bench for tlc_request_latch: reset, latency, glitch rejection,
// service clearing, starvation and mid-operation reset.
module tb_tlc_request_latch;

   logic       clkdiv = 1'b0;
   logic       rst;
   logic [3:0] sensor_raw;
   logic [3:0] G;
   logic [3:0] t;
   logic [2:0] pending_cnt;
   logic [3:0] starved;

   int checks   = 0;
   int failures = 0;

   tlc_request_latch dut (
      .clkdiv      (clkdiv),
      .rst         (rst),
      .sensor_raw  (sensor_raw),
      .G           (G),
      .t           (t),
      .pending_cnt (pending_cnt),
      .starved     (starved)
   );

   always #5 clkdiv = ~clkdiv;

   task automatic tick();
      @(posedge clkdiv);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; sensor_raw = 4'h0; G = 4'h0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; sensor_raw = 4'hF; G = 4'h0;
      for (int e = 0; e < 2; e++) begin
         tick();
         checks++;
         if (t !== 4'h0 || starved !== 4'h0 || pending_cnt !== 3'd0) begin
            failures++;
            $display("FAIL reset_hold edge=%0d t=%b starved=%b pend=%0d required 0/0/0", e, t, starved, pending_cnt);
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if (t !== 4'h0 || starved !== 4'h0 || pending_cnt !== 3'd0) begin
         failures++;
         $display("FAIL reset_release t=%b starved=%b pend=%0d required 0/0/0", t, starved, pending_cnt);
      end
   endtask

   task automatic test_latency();
      do_reset();
      sensor_raw = 4'b0100;
      for (int e = 1; e <= 6; e++) begin
         tick();
         checks++;
         if (t !== 4'h0) begin
            failures++;
            $display("FAIL latency_early edge=k+%0d t=%b required 0000", e - 1, t);
         end
      end
      tick();
      checks++;
      if (t !== 4'b0100 || pending_cnt !== 3'd1) begin
         failures++;
         $display("FAIL latency_set t=%b pend=%0d required 0100/1", t, pending_cnt);
      end
   endtask

   task automatic test_glitch();
      do_reset();
      sensor_raw = 4'b0010;
      repeat (3) tick();
      sensor_raw = 4'b0000;
      repeat (15) tick();
      checks++;
      if (t !== 4'h0) begin
         failures++;
         $display("FAIL glitch_3cyc t=%b required 0000", t);
      end
      sensor_raw = 4'b0010;
      repeat (4) tick();
      sensor_raw = 4'b0000;
      repeat (15) tick();
      checks++;
      if (t !== 4'b0010 || pending_cnt !== 3'd1) begin
         failures++;
         $display("FAIL glitch_4cyc t=%b pend=%0d required 0010/1", t, pending_cnt);
      end
   endtask

   task automatic test_served();
      do_reset();
      sensor_raw = 4'b0101;
      repeat (8) tick();
      checks++;
      if (t !== 4'b0101 || pending_cnt !== 3'd2) begin
         failures++;
         $display("FAIL served_pre t=%b pend=%0d required 0101/2", t, pending_cnt);
      end
      G = 4'b0001;
      tick();
      checks++;
      if (t !== 4'b0100 || pending_cnt !== 3'd1) begin
         failures++;
         $display("FAIL served_clear t=%b pend=%0d required 0100/1", t, pending_cnt);
      end
      for (int e = 0; e < 3; e++) begin
         tick();
         checks++;
         if (t !== 4'b0100) begin
            failures++;
            $display("FAIL served_green_hold edge=%0d t=%b required 0100", e, t);
         end
      end
      G = 4'b0000;
      tick();
      checks++;
      if (t !== 4'b0101) begin
         failures++;
         $display("FAIL served_relatch t=%b required 0101", t);
      end
   endtask

   task automatic test_starvation();
      do_reset();
      sensor_raw = 4'b1000;
      repeat (7) tick();
      checks++;
      if (t !== 4'b1000) begin
         failures++;
         $display("FAIL starve_setup t=%b required 1000", t);
      end
      repeat (199) tick();
      checks++;
      if (starved !== 4'b0000) begin
         failures++;
         $display("FAIL starve_early starved=%b required 0000", starved);
      end
      tick();
      checks++;
      if (starved !== 4'b1000) begin
         failures++;
         $display("FAIL starve_at_200 starved=%b required 1000", starved);
      end
      repeat (60) tick();
      checks++;
      if (starved !== 4'b1000 || t !== 4'b1000) begin
         failures++;
         $display("FAIL starve_saturate starved=%b t=%b required 1000/1000", starved, t);
      end
      G = 4'b1000;
      tick();
      checks++;
      if (starved !== 4'b0000 || t !== 4'b0000) begin
         failures++;
         $display("FAIL starve_served starved=%b t=%b required 0000/0000", starved, t);
      end
      G = 4'b0000;
      sensor_raw = 4'b0000;
   endtask

   task automatic test_mid_reset();
      do_reset();
      sensor_raw = 4'b0100;
      repeat (7) tick();
      repeat (50) tick();
      checks++;
      if (t !== 4'b0100 || starved !== 4'b0000) begin
         failures++;
         $display("FAIL midrst_setup t=%b starved=%b required 0100/0000", t, starved);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (t !== 4'h0 || starved !== 4'h0 || pending_cnt !== 3'd0) begin
         failures++;
         $display("FAIL midrst_clear t=%b starved=%b pend=%0d required 0/0/0", t, starved, pending_cnt);
      end
      for (int e = 1; e <= 6; e++) begin
         tick();
         checks++;
         if (t !== 4'h0) begin
            failures++;
            $display("FAIL midrst_early edge=%0d t=%b required 0000", e, t);
         end
      end
      tick();
      checks++;
      if (t !== 4'b0100) begin
         failures++;
         $display("FAIL midrst_relatch t=%b required 0100", t);
      end
   endtask

   initial begin
      rst = 1'b1; sensor_raw = 4'h0; G = 4'h0;
      test_reset();
      test_latency();
      test_glitch();
      test_served();
      test_starvation();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
